// File: rtl/mem_bist_if.sv
// Memory-side port of the BIST sequencer: write/read strobes, address and data.
// master = sequencer, slave = memory.
interface mem_bist_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data_in;
    logic [7:0]        mem_data_out;

    modport master (
        output mem_write,
        output mem_read,
        output mem_addr,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  mem_write,
        input  mem_read,
        input  mem_addr,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: CLEAR, ADDR and RAND write/verify passes over the whole
// memory, with saturating error count and first-mismatch capture.
module mem_bist_ctrl #(
    parameter int unsigned ADDR_W    = 5,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    mem_bist_if.master        mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [1:0]        first_err_phase
);

    localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
    localparam logic [7:0]        Seed     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    localparam logic [1:0] PhClear = 2'd0;
    localparam logic [1:0] PhAddr  = 2'd1;
    localparam logic [1:0] PhRand  = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StChk,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic [1:0]        first_err_phase_q, first_err_phase_d;

    logic       mem_write_c;
    logic       mem_read_c;
    logic [7:0] mem_data_in_c;
    logic [7:0] expected;
    logic [7:0] lfsr_next;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        case (phase_q)
            PhClear: expected = 8'h00;
            PhAddr:  expected = 8'(addr_q);
            default: expected = lfsr_q;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        phase_d           = phase_q;
        addr_d            = addr_q;
        lfsr_d            = lfsr_q;
        err_count_d       = err_count_q;
        first_err_addr_d  = first_err_addr_q;
        first_err_phase_d = first_err_phase_q;
        mem_write_c       = 1'b0;
        mem_read_c        = 1'b0;
        mem_data_in_c     = 8'h00;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d           = StWr;
                    phase_d           = PhClear;
                    addr_d            = '0;
                    err_count_d       = 8'h00;
                    first_err_addr_d  = '0;
                    first_err_phase_d = PhClear;
                end
            end
            StWr: begin
                mem_write_c   = 1'b1;
                mem_data_in_c = expected;
                if (phase_q == PhRand) begin
                    lfsr_d = lfsr_next;
                end
                if (addr_q == LastAddr) begin
                    state_d = StRd;
                    addr_d  = '0;
                    // Verify pass replays the RAND sequence from the seed.
                    if (phase_q == PhRand) begin
                        lfsr_d = Seed;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StRd: begin
                mem_read_c = 1'b1;
                state_d    = StChk;
            end
            StChk: begin
                if (mem.mem_data_out != expected) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    // A zero count means no mismatch seen yet in this run.
                    if (err_count_q == 8'h00) begin
                        first_err_addr_d  = addr_q;
                        first_err_phase_d = phase_q;
                    end
                end
                if (phase_q == PhRand) begin
                    lfsr_d = lfsr_next;
                end
                if (addr_q == LastAddr) begin
                    addr_d = '0;
                    if (phase_q == PhRand) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWr;
                        phase_d = phase_q + 2'd1;
                        if (phase_q == PhAddr) begin
                            lfsr_d = Seed;
                        end
                    end
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            phase_q           <= PhClear;
            addr_q            <= '0;
            lfsr_q            <= Seed;
            err_count_q       <= 8'h00;
            first_err_addr_q  <= '0;
            first_err_phase_q <= PhClear;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            addr_q            <= addr_d;
            lfsr_q            <= lfsr_d;
            err_count_q       <= err_count_d;
            first_err_addr_q  <= first_err_addr_d;
            first_err_phase_q <= first_err_phase_d;
        end
    end

    assign mem.mem_write   = mem_write_c;
    assign mem.mem_read    = mem_read_c;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_data_in = mem_data_in_c;

    assign busy            = (state_q == StWr) || (state_q == StRd) || (state_q == StChk);
    assign done            = (state_q == StDone);
    assign pass            = done && (err_count_q == 8'h00);
    assign err_count       = err_count_q;
    assign first_err_addr  = first_err_addr_q;
    assign first_err_phase = first_err_phase_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: timeline model of a run checked every cycle, plus
// literal expectations for fault scenarios, restart, reset and saturation.
module tb_mem_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [4:0] first_err_addr;
    logic [1:0] first_err_phase;

    logic       big_start;
    logic       big_busy, big_done, big_pass;
    logic [7:0] big_err_count;
    logic [7:0] big_first_err_addr;
    logic [1:0] big_first_err_phase;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_bist_if #(.ADDR_W(5)) mif ();
    mem_bist_if #(.ADDR_W(8)) big_if ();

    mem_bist_ctrl #(.ADDR_W(5), .LFSR_SEED(8'hA5)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mem             (mif.master),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr),
        .first_err_phase (first_err_phase)
    );

    mem_bist_ctrl #(.ADDR_W(8), .LFSR_SEED(8'hA5)) big_dut (
        .clk             (clk),
        .rst             (rst),
        .start           (big_start),
        .mem             (big_if.master),
        .busy            (big_busy),
        .done            (big_done),
        .pass            (big_pass),
        .err_count       (big_err_count),
        .first_err_addr  (big_first_err_addr),
        .first_err_phase (big_first_err_phase)
    );

    // Memory model. fault: 0 none, 1 bit3 stuck-at-1 at addr 5, 2 reads return FF.
    int         fault;
    logic [7:0] mem_arr [32];
    logic [7:0] rdata;
    assign mif.mem_data_out    = rdata;
    assign big_if.mem_data_out = 8'hFF;

    function automatic logic [7:0] mem_return(input int f, input int a, input logic [7:0] s);
        if (f == 2) return 8'hFF;
        if (f == 1 && a == 5) return s | 8'h08;
        return s;
    endfunction

    always @(posedge clk) begin
        if (mif.mem_write) mem_arr[mif.mem_addr] <= mif.mem_data_in;
        if (mif.mem_read) rdata <= mem_return(fault, int'(mif.mem_addr), mem_arr[mif.mem_addr]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: a run is 3 phases of 96 cycles; cycle j of a phase writes
    // address j for j<32, then alternates read(addr)/check.
    function automatic logic [7:0] lfsr_at(input int idx);
        logic [7:0] q;
        q = 8'hA5;
        for (int i = 0; i < idx; i++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        return q;
    endfunction

    function automatic logic [7:0] exp_data(input int ph, input int a);
        if (ph == 0) return 8'h00;
        if (ph == 1) return 8'(a);
        return lfsr_at(a);
    endfunction

    task automatic model_run(input int f, output int e, output int fa, output int fp);
        e = 0; fa = 0; fp = 0;
        for (int ph = 0; ph < 3; ph++)
            for (int a = 0; a < 32; a++)
                if (mem_return(f, a, exp_data(ph, a)) != exp_data(ph, a)) begin
                    if (e == 0) begin fa = a; fp = ph; end
                    e++;
                end
        if (e > 255) e = 255;
    endtask

    logic m_in_run = 1'b0;
    logic m_done   = 1'b0;
    int   m_k      = 0;
    int   m_err, m_fa, m_fp;

    always @(posedge clk) begin : model_seq
        int e, fa, fp;
        if (rst) begin
            m_in_run <= 1'b0;
            m_done   <= 1'b0;
        end else if (m_in_run) begin
            if (m_k == 287) begin
                m_in_run <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (start) begin
            model_run(fault, e, fa, fp);
            m_err    <= e;
            m_fa     <= fa;
            m_fp     <= fp;
            m_in_run <= 1'b1;
            m_done   <= 1'b0;
            m_k      <= 0;
        end
    end

    logic       checking = 1'b0;
    int         wr_cnt, rd_cnt;
    logic [7:0] rand_cap [3];

    always @(negedge clk) begin : compare
        int ph, j, r;
        if (checking) begin
            if (mif.mem_write) wr_cnt++;
            if (mif.mem_read) rd_cnt++;
            chk("strobe_overlap", 32'(mif.mem_write & mif.mem_read), 0);
            if (m_in_run) begin
                ph = m_k / 96;
                j  = m_k % 96;
                chk("busy_run", 32'(busy), 1);
                chk("done_run", 32'(done), 0);
                if (j < 32) begin
                    chk("mem_write", 32'(mif.mem_write), 1);
                    chk("wr_addr", 32'(mif.mem_addr), 32'(j));
                    chk("wr_data", 32'(mif.mem_data_in), 32'(exp_data(ph, j)));
                    if (ph == 2 && j < 3) rand_cap[j] = mif.mem_data_in;
                end else begin
                    r = j - 32;
                    chk("mem_write", 32'(mif.mem_write), 0);
                    chk("mem_read", 32'(mif.mem_read), 32'(r % 2 == 0));
                    if (r % 2 == 0) chk("rd_addr", 32'(mif.mem_addr), 32'(r / 2));
                end
            end else begin
                chk("busy_idle", 32'(busy), 0);
                chk("done_idle", 32'(done), 32'(m_done));
                chk("strobes_idle", 32'(mif.mem_write | mif.mem_read), 0);
                if (m_done) begin
                    chk("pass", 32'(pass), 32'(m_err == 0));
                    chk("err_count", 32'(err_count), 32'(m_err));
                    chk("first_err_addr", 32'(first_err_addr), 32'(m_fa));
                    chk("first_err_phase", 32'(first_err_phase), 32'(m_fp));
                end
            end
        end
    end

    task automatic run_start();
        @(negedge clk);
        wr_cnt = 0;
        rd_cnt = 0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done), 1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        big_start = 1'b0;
        fault     = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_first", 32'({first_err_addr, first_err_phase}), 0);
        chk("rst_bus", 32'({mif.mem_write, mif.mem_read, mif.mem_addr, mif.mem_data_in}), 0);
        rst      = 1'b0;
        checking = 1'b1;

        // Fault-free run.
        run_start();
        wait_done(400, n);
        chk("run_len", 32'(n), 288);
        chk("wr_count", 32'(wr_cnt), 96);
        chk("rd_count", 32'(rd_cnt), 96);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_err", 32'(err_count), 0);
        chk("rand0", 32'(rand_cap[0]), 32'h A5);
        chk("rand1", 32'(rand_cap[1]), 32'h 4A);
        chk("rand2", 32'(rand_cap[2]), 32'h 95);

        // Bit 3 stuck-at-1 at addr 5: CLEAR and ADDR miss, RAND value A9 hides it.
        fault = 1;
        run_start();
        wait_done(400, n);
        chk("stuck_err", 32'(err_count), 2);
        chk("stuck_addr", 32'(first_err_addr), 5);
        chk("stuck_phase", 32'(first_err_phase), 0);
        chk("stuck_pass", 32'(pass), 0);

        // Every read returns FF.
        fault = 2;
        run_start();
        wait_done(400, n);
        chk("ff_first", 32'({first_err_addr, first_err_phase}), 0);
        chk("ff_pass", 32'(pass), 0);

        // Re-pulsed start mid-run is ignored.
        fault = 0;
        run_start();
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400, n);
        chk("repulse_len", 32'(n + 51), 288);

        // Reset in the ADDR phase abandons the run.
        run_start();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_bus", 32'({mif.mem_write, mif.mem_read, mif.mem_addr, mif.mem_data_in}), 0);
        chk("midrst_err", 32'(err_count), 0);
        repeat (3) @(negedge clk);
        run_start();
        wait_done(400, n);
        chk("after_rst_len", 32'(n), 288);
        chk("after_rst_pass", 32'(pass), 1);

        // 256-deep instance with all-FF reads: enough mismatches to saturate.
        @(negedge clk);
        big_start = 1'b1;
        @(negedge clk);
        big_start = 1'b0;
        n = 0;
        while (big_done !== 1'b1 && n < 2400) begin
            @(negedge clk);
            n++;
        end
        chk("big_len", 32'(n), 2304);
        chk("big_err_sat", 32'(big_err_count), 255);
        chk("big_pass", 32'(big_pass), 0);
        chk("big_first", 32'({big_first_err_addr, big_first_err_phase}), 0);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
